// File: rtl/pe_output_writeback.sv
// pe_output_writeback: buffers PE output vectors, rebases addresses onto a GB window, writes them out, signals job done.
// Optional gb_stall_cnt port and counter enabled by PE_OUTPUT_WRITEBACK_STALL_STATS_EN.
module pe_output_writeback #(
    parameter int DEPTH     = 4,
    parameter int GB_ADDR_W = 16,
    parameter int DATA_W    = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic [GB_ADDR_W-1:0] cfg_base,
    input  logic [7:0]           cfg_num,
    input  logic [DATA_W+7:0]    in_msg,
    input  logic                 in_val,
    output logic                 in_rdy,
    output logic [GB_ADDR_W-1:0] gb_wr_addr,
    output logic [DATA_W-1:0]    gb_wr_data,
    output logic                 gb_wr_val,
    input  logic                 gb_wr_rdy,
    output logic                 done_val,
    input  logic                 done_rdy,
    output logic                 busy
`ifdef PE_OUTPUT_WRITEBACK_STALL_STATS_EN
    ,
    output logic [15:0]          gb_stall_cnt
`endif
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [GB_ADDR_W-1:0] base_q, base_d;
    logic [8:0]           num_q, num_d, enq_cnt_q, enq_cnt_d, deq_cnt_q, deq_cnt_d;
    logic [AW-1:0]        wp_q, wp_d, rp_q, rp_d;
    logic [AW:0]          cnt_q, cnt_d;
    logic [DATA_W+7:0]    mem_q [DEPTH];
    logic [DATA_W+7:0]    mem_d [DEPTH];
    logic                 full, empty, enq, deq;

    always_comb begin
        full       = cnt_q == (AW+1)'(DEPTH);
        empty      = cnt_q == '0;
        in_rdy     = state_q == RUN && !full && enq_cnt_q < num_q;
        gb_wr_val  = state_q == RUN && !empty;
        // outputs are forced to zero whenever no write is offered so reset/idle values are deterministic
        gb_wr_addr = gb_wr_val ? base_q + GB_ADDR_W'(mem_q[rp_q][DATA_W+:8]) : '0;
        gb_wr_data = gb_wr_val ? mem_q[rp_q][DATA_W-1:0] : '0;
        done_val   = state_q == DONE;
        busy       = state_q != IDLE;
        enq        = in_val && in_rdy;
        deq        = gb_wr_val && gb_wr_rdy;
        mem_d      = mem_q;
        wp_d       = wp_q + AW'(enq);
        rp_d       = rp_q + AW'(deq);
        cnt_d      = cnt_q + (AW+1)'(enq) - (AW+1)'(deq);
        enq_cnt_d  = enq_cnt_q + 9'(enq);
        deq_cnt_d  = deq_cnt_q + 9'(deq);
        base_d     = base_q;
        num_d      = num_q;
        state_d    = state_q;
        if (enq)
            mem_d[wp_q] = in_msg;
        case (state_q)
            IDLE: if (cfg_start) begin
                base_d    = cfg_base;
                num_d     = cfg_num == 8'd0 ? 9'd256 : {1'b0, cfg_num};
                enq_cnt_d = '0;
                deq_cnt_d = '0;
                state_d   = RUN;
            end
            RUN:     state_d = deq && deq_cnt_d == num_q ? DONE : RUN;
            DONE:    state_d = done_rdy ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            base_q    <= '0;
            num_q     <= '0;
            enq_cnt_q <= '0;
            deq_cnt_q <= '0;
            wp_q      <= '0;
            rp_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            num_q     <= num_d;
            enq_cnt_q <= enq_cnt_d;
            deq_cnt_q <= deq_cnt_d;
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            cnt_q     <= cnt_d;
        end
    end

    // storage needs no reset: occupancy is cleared and outputs are gated on it
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef PE_OUTPUT_WRITEBACK_STALL_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = state_q == IDLE && cfg_start ? 16'd0 :
                  gb_wr_val && !gb_wr_rdy && stall_q != 16'hFFFF ? stall_q + 16'd1 : stall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_q <= '0;
        else
            stall_q <= stall_d;
    end

    assign gb_stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_pe_output_writeback.sv
// tb_pe_output_writeback: randomized bench with a queue-based job model checked every cycle.
module tb_pe_output_writeback;
    localparam int DEPTH = 4;

    logic         clk = 0, rst = 1, cfg_start = 0, in_val = 0, gb_wr_rdy = 0, done_rdy = 0;
    logic [15:0]  cfg_base = '0;
    logic [7:0]   cfg_num = '0;
    logic [135:0] in_msg = '0;
    logic         in_rdy, gb_wr_val, done_val, busy;
    logic [15:0]  gb_wr_addr;
    logic [127:0] gb_wr_data;
`ifdef PE_OUTPUT_WRITEBACK_STALL_STATS_EN
    logic [15:0]  gb_stall_cnt;
`endif

    pe_output_writeback #(.DEPTH(DEPTH), .GB_ADDR_W(16), .DATA_W(128)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base(cfg_base), .cfg_num(cfg_num),
        .in_msg(in_msg), .in_val(in_val), .in_rdy(in_rdy),
        .gb_wr_addr(gb_wr_addr), .gb_wr_data(gb_wr_data), .gb_wr_val(gb_wr_val), .gb_wr_rdy(gb_wr_rdy),
        .done_val(done_val), .done_rdy(done_rdy), .busy(busy)
`ifdef PE_OUTPUT_WRITEBACK_STALL_STATS_EN
        , .gb_stall_cnt(gb_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int rdy_pct = 100, val_pct = 100, done_pct = 100;
    bit acc_seen = 0;
    int acc_n = 0;
    logic [135:0] src[$];
    logic [143:0] wlog[$];

    // reference: job phase 0=idle 1=run 2=done, pending vectors in a queue
    int m_st = 0, m_base = 0, m_num = 0, m_enq = 0, m_wr = 0, m_stall = 0;
    logic [135:0] m_q[$];

    task automatic check(input string name, input logic [143:0] got, input logic [143:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    initial forever begin
        bit fin;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_st = 0; m_enq = 0; m_wr = 0; m_stall = 0;
            m_q.delete();
        end else begin
            fin = m_st == 1 && in_val && m_q.size() < DEPTH && m_enq < m_num;
            if (m_st == 0 && cfg_start) begin
                m_base = int'(cfg_base);
                m_num = cfg_num == 0 ? 256 : int'(cfg_num);
                m_enq = 0; m_wr = 0; m_stall = 0; m_st = 1;
            end else if (m_st == 1) begin
                if (m_q.size() > 0 && !gb_wr_rdy && m_stall < 65535) m_stall++;
                if (m_q.size() > 0 && gb_wr_rdy) begin
                    void'(m_q.pop_front());
                    m_wr++;
                    if (m_wr == m_num) m_st = 2;
                end
                if (fin) begin
                    m_q.push_back(in_msg);
                    m_enq++;
                end
            end else if (m_st == 2 && done_rdy) begin
                m_st = 0;
            end
        end
    end

    initial forever begin
        bit e_rdy, e_wv;
        int a;
        @(negedge clk);
        e_rdy = m_st == 1 && m_q.size() < DEPTH && m_enq < m_num;
        e_wv = m_st == 1 && m_q.size() > 0;
        check("in_rdy", in_rdy, e_rdy);
        check("gb_wr_val", gb_wr_val, e_wv);
        check("done_val", done_val, m_st == 2);
        check("busy", busy, m_st != 0);
        if (e_wv) begin
            a = (m_base + int'(m_q[0][135:128])) % 65536;
            check("gb_wr_addr", gb_wr_addr, a);
            check("gb_wr_data", gb_wr_data, m_q[0][127:0]);
        end
`ifdef PE_OUTPUT_WRITEBACK_STALL_STATS_EN
        check("gb_stall_cnt", gb_stall_cnt, m_stall);
`endif
        acc_seen = in_val && in_rdy;
        if (acc_seen) acc_n++;
        if (gb_wr_val && gb_wr_rdy) wlog.push_back({gb_wr_addr, gb_wr_data});
    end

    initial forever begin
        bit hold;
        @(posedge clk);
        #1;
        if (acc_seen && src.size() > 0) void'(src.pop_front());
        hold = in_val && !acc_seen;
        in_val = src.size() > 0 && (hold || $urandom_range(99) < val_pct);
        in_msg = src.size() > 0 ? src[0] : '0;
        gb_wr_rdy = $urandom_range(99) < rdy_pct;
        done_rdy = $urandom_range(99) < done_pct;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_vecs(input int n, input int addr);
        for (int i = 0; i < n; i++)
            src.push_back({addr < 0 ? 8'($urandom) : 8'(addr), $urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic start_job(input logic [15:0] b, input logic [7:0] n);
        wlog.delete();
        acc_n = 0;
        cfg_base = b;
        cfg_num = n;
        cfg_start = 1;
        tick();
        cfg_start = 0;
    endtask

    task automatic wait_idle(input int budget, input bit noise);
        for (int c = 0; c < budget && m_st != 0; c++) begin
            cfg_start = noise && $urandom_range(3) == 0;
            cfg_base = 16'($urandom);
            cfg_num = 8'($urandom);
            tick();
            cfg_start = 0;
        end
        check("job_finished_idle", busy, 0);
        src.delete();
    endtask

    initial begin
        int bad, n;
        logic [135:0] v0;
        repeat (2) @(negedge clk);
        check("rst_in_rdy", in_rdy, 0);
        check("rst_gb_wr_val", gb_wr_val, 0);
        check("rst_gb_wr_addr", gb_wr_addr, 0);
        check("rst_gb_wr_data", gb_wr_data, 0);
        check("rst_done_val", done_val, 0);
        check("rst_busy", busy, 0);
        tick();
        rst = 0;
        tick();

        src.push_back({8'd0, {32{4'hA}}});
        src.push_back({8'd1, {32{4'hB}}});
        src.push_back({8'd2, {32{4'hC}}});
        start_job(16'h1000, 8'd3);
        wait_idle(50, 0);
        check("basic_writes", wlog.size(), 3);
        check("basic_acc", acc_n, 3);
        if (wlog.size() == 3) begin
            check("basic_w0", wlog[0], {16'h1000, {32{4'hA}}});
            check("basic_w1", wlog[1], {16'h1001, {32{4'hB}}});
            check("basic_w2", wlog[2], {16'h1002, {32{4'hC}}});
        end

        rdy_pct = 0;
        push_vecs(6, -1);
        start_job(16'($urandom), 8'd6);
        repeat (10) tick();
        check("bp_acc", acc_n, 4);
        check("bp_in_rdy", in_rdy, 0);
        rdy_pct = 100;
        wait_idle(100, 0);
        check("bp_writes", wlog.size(), 6);

        push_vecs(256, 1);
        start_job(16'hFFFF, 8'd0);
        wait_idle(2000, 0);
        check("wrap_writes", wlog.size(), 256);
        bad = 0;
        foreach (wlog[i]) if (wlog[i][143:128] != 16'h0000) bad++;
        check("wrap_addr_nonzero", bad, 0);

        push_vecs(5, -1);
        start_job(16'($urandom), 8'd2);
        wait_idle(100, 1);
        check("excess_acc", acc_n, 2);
        check("excess_writes", wlog.size(), 2);

        for (int j = 0; j < 8; j++) begin
            rdy_pct = $urandom_range(30, 100);
            val_pct = $urandom_range(30, 100);
            done_pct = $urandom_range(30, 100);
            n = $urandom_range(1, 20);
            push_vecs(n + $urandom_range(0, 3), -1);
            start_job(16'($urandom), 8'(n));
            wait_idle(2000, 1);
            check("rand_writes", wlog.size(), n);
        end
        val_pct = 100;
        done_pct = 100;

        rdy_pct = 0;
        push_vecs(3, -1);
        start_job(16'h2000, 8'd5);
        for (int c = 0; c < 20 && acc_n < 3; c++) tick();
        @(negedge clk);
        #2 rst = 1;
        #1;
        check("mid_rst_gb_wr_val", gb_wr_val, 0);
        check("mid_rst_done_val", done_val, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_rdy", in_rdy, 0);
        src.delete();
        tick();
        tick();
        rst = 0;
        rdy_pct = 100;
        tick();
        push_vecs(2, 5);
        v0 = src[0];
        start_job(16'h0100, 8'd2);
        wait_idle(100, 0);
        check("post_rst_writes", wlog.size(), 2);
        if (wlog.size() > 0) check("post_rst_w0", wlog[0], {16'h0105, v0[127:0]});

`ifdef PE_OUTPUT_WRITEBACK_STALL_STATS_EN
        rdy_pct = 0;
        push_vecs(1, -1);
        start_job(16'h0000, 8'd1);
        for (int c = 0; c < 20 && !gb_wr_val; c++) @(negedge clk);
        repeat (6) @(negedge clk);
        rdy_pct = 100;
        wait_idle(100, 0);
        check("stats_cnt", gb_stall_cnt, 7);
        push_vecs(1, -1);
        start_job(16'h0000, 8'd1);
        check("stats_cleared", gb_stall_cnt, 0);
        wait_idle(100, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
